// File: rtl/cc_demux14.sv
// cc_demux14: 1-to-4 demultiplexer with a one-word holding register per output lane.
// The input handshake stalls only while the selected lane is full and not draining.
// A lane that drains and refills in the same cycle takes the new word with no bubble.
// Optional per-lane 8-bit transfer counters are enabled by defining CC_DEMUX14_COUNT_EN.
module cc_demux14 #(
  parameter int unsigned DEMUX14_DATAWIDTH = 4
) (
  input  logic                           CC_DEMUX14_CLOCK_50,
  input  logic                           CC_DEMUX14_RESET_InHigh,
  input  logic [DEMUX14_DATAWIDTH-1:0]   CC_DEMUX14_data_InBUS,
  input  logic [1:0]                     CC_DEMUX14_select_InBUS,
  input  logic                           CC_DEMUX14_valid_In,
  output logic                           CC_DEMUX14_ready_Out,
  output logic [4*DEMUX14_DATAWIDTH-1:0] CC_DEMUX14_z_OutBus,
  output logic [3:0]                     CC_DEMUX14_valid_OutBus,
`ifdef CC_DEMUX14_COUNT_EN
  output logic [31:0]                    CC_DEMUX14_count_OutBus,
`endif
  input  logic [3:0]                     CC_DEMUX14_ready_InBus
);

  localparam int unsigned W = DEMUX14_DATAWIDTH;

  logic [W-1:0] r_data [4];
  logic [3:0]   r_full;

  logic         w_in_xfer;
  logic [3:0]   w_lane_xfer;
  logic [3:0]   w_load;

  // Handshake decode: input accept, per-lane drain and per-lane load strobes.
  always_comb begin
    CC_DEMUX14_ready_Out = !r_full[CC_DEMUX14_select_InBUS] ||
                           CC_DEMUX14_ready_InBus[CC_DEMUX14_select_InBUS];
    w_in_xfer            = CC_DEMUX14_valid_In && CC_DEMUX14_ready_Out;
    w_lane_xfer          = r_full & CC_DEMUX14_ready_InBus;
    w_load               = 4'b0000;
    w_load[CC_DEMUX14_select_InBUS] = w_in_xfer;
  end

  // Lane state: load wins over drain so a simultaneous refill keeps the lane full.
  always_ff @(posedge CC_DEMUX14_CLOCK_50 or posedge CC_DEMUX14_RESET_InHigh) begin
    if (CC_DEMUX14_RESET_InHigh) begin
      r_full <= 4'b0000;
      for (int k = 0; k < 4; k++) begin
        r_data[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_load[k]) begin
          r_data[k] <= CC_DEMUX14_data_InBUS;
          r_full[k] <= 1'b1;
        end else if (w_lane_xfer[k]) begin
          r_full[k] <= 1'b0;
        end
      end
    end
  end

  // Lane outputs: full flag is the lane valid, data is held until the next load.
  always_comb begin
    CC_DEMUX14_valid_OutBus = r_full;
    CC_DEMUX14_z_OutBus     = '0;
    for (int k = 0; k < 4; k++) begin
      CC_DEMUX14_z_OutBus[k*W +: W] = r_data[k];
    end
  end

`ifdef CC_DEMUX14_COUNT_EN
  logic [7:0] r_count [4];

  // Per-lane transfer counters, wrapping naturally at 8 bits.
  always_ff @(posedge CC_DEMUX14_CLOCK_50 or posedge CC_DEMUX14_RESET_InHigh) begin
    if (CC_DEMUX14_RESET_InHigh) begin
      for (int k = 0; k < 4; k++) begin
        r_count[k] <= 8'd0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_lane_xfer[k]) begin
          r_count[k] <= r_count[k] + 8'd1;
        end
      end
    end
  end

  // Pack the counters, lane k in byte k.
  always_comb begin
    CC_DEMUX14_count_OutBus = '0;
    for (int k = 0; k < 4; k++) begin
      CC_DEMUX14_count_OutBus[8*k +: 8] = r_count[k];
    end
  end
`endif

endmodule

// File: tb/tb_cc_demux14.sv
// Bench for cc_demux14: a lane model plus per-lane expected-word queues.
// Words are queued when the model says the input is accepted and popped when a lane drains.
module tb_cc_demux14;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   din;
  logic [1:0]     sel;
  logic           vin;
  logic           rdy_o;
  logic [4*W-1:0] z;
  logic [3:0]     vout;
  logic [3:0]     rdy_in;
`ifdef CC_DEMUX14_COUNT_EN
  logic [31:0]    cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] exp_q [4][$];
  bit           m_full [4];
  int           m_cnt [4];

  always #5 clk = ~clk;

  cc_demux14 #(.DEMUX14_DATAWIDTH(W)) dut (
    .CC_DEMUX14_CLOCK_50     (clk),
    .CC_DEMUX14_RESET_InHigh (rst),
    .CC_DEMUX14_data_InBUS   (din),
    .CC_DEMUX14_select_InBUS (sel),
    .CC_DEMUX14_valid_In     (vin),
    .CC_DEMUX14_ready_Out    (rdy_o),
    .CC_DEMUX14_z_OutBus     (z),
    .CC_DEMUX14_valid_OutBus (vout),
`ifdef CC_DEMUX14_COUNT_EN
    .CC_DEMUX14_count_OutBus (cnt),
`endif
    .CC_DEMUX14_ready_InBus  (rdy_in)
  );

  task automatic clear_model();
    for (int k = 0; k < 4; k++) begin
      exp_q[k].delete();
      m_full[k] = 1'b0;
      m_cnt[k]  = 0;
    end
  endtask

  // One clock cycle with inputs already driven after a falling edge.
  task automatic cycle();
    logic         m_rdy;
    logic [W-1:0] got;
    logic [W-1:0] exp;
    #1;
    m_rdy = !m_full[sel] || rdy_in[sel];
    n_cmp++;
    if (rdy_o !== m_rdy) begin
      n_err++;
      $display("FAIL ready_out sel=%0d: got %b need %b", sel, rdy_o, m_rdy);
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (vout[k] !== m_full[k]) begin
        n_err++;
        $display("FAIL valid_lane%0d: got %b need %b", k, vout[k], m_full[k]);
      end
`ifdef CC_DEMUX14_COUNT_EN
      n_cmp++;
      if (cnt[8*k +: 8] !== 8'(m_cnt[k])) begin
        n_err++;
        $display("FAIL count_lane%0d: got %0d need %0d", k, cnt[8*k +: 8], m_cnt[k]);
      end
`endif
      if (m_full[k] && rdy_in[k]) begin
        got = z[k*W +: W];
        n_cmp++;
        if (exp_q[k].size() == 0) begin
          n_err++;
          $display("FAIL lane%0d_underflow: got %h need no word", k, got);
        end else begin
          exp = exp_q[k].pop_front();
          if (got !== exp) begin
            n_err++;
            $display("FAIL lane%0d_data: got %h need %h", k, got, exp);
          end
        end
        m_full[k] = 1'b0;
        m_cnt[k]  = (m_cnt[k] + 1) % 256;
      end
    end
    if (vin && m_rdy) begin
      exp_q[sel].push_back(din);
      m_full[sel] = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [1:0] s, input logic [W-1:0] d);
    vin = 1'b1; sel = s; din = d; rdy_in = 4'b0000;
    cycle();
    vin = 1'b0;
  endtask

  task automatic test_reset();
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      n_cmp++;
      if (rdy_o !== 1'b1) begin
        n_err++;
        $display("FAIL reset_ready sel=%0d: got %b need 1", s, rdy_o);
      end
    end
    n_cmp++;
    if (vout !== 4'b0000 || z !== '0) begin
      n_err++;
      $display("FAIL reset_state: got valid=%b z=%h need 0000/0", vout, z);
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    send(2'd2, 4'hA);
    #1;
    n_cmp++;
    if (vout !== 4'b0100 || z[2*W +: W] !== 4'hA) begin
      n_err++;
      $display("FAIL basic_route: got valid=%b lane2=%h need 0100/a", vout, z[2*W +: W]);
    end
    rdy_in = 4'b0100;
    cycle();
    rdy_in = 4'b0000;
    #1;
    n_cmp++;
    if (vout !== 4'b0000) begin
      n_err++;
      $display("FAIL basic_drain: got valid=%b need 0000", vout);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    send(2'd1, 4'h9);
    vin = 1'b1; sel = 2'd1; din = 4'h5; rdy_in = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_cmp++;
      if (rdy_o !== 1'b0 || z[W +: W] !== 4'h9) begin
        n_err++;
        $display("FAIL backpressure_hold cyc=%0d: got rdy=%b lane1=%h need 0/9", i, rdy_o,
                 z[W +: W]);
      end
      #1;
      cycle();
    end
    vin = 1'b0; rdy_in = 4'b0010;
    cycle();
    rdy_in = 4'b0000;
  endtask

  task automatic test_refill();
    send(2'd0, 4'h3);
    vin = 1'b1; sel = 2'd0; din = 4'h7; rdy_in = 4'b0001;
    cycle();
    vin = 1'b0; rdy_in = 4'b0000;
    #1;
    n_cmp++;
    if (vout[0] !== 1'b1 || z[0 +: W] !== 4'h7) begin
      n_err++;
      $display("FAIL refill_lane0: got valid=%b data=%h need 1/7", vout[0], z[0 +: W]);
    end
    @(negedge clk);
    rdy_in = 4'b0001;
    cycle();
    rdy_in = 4'b0000;
  endtask

  task automatic test_concurrency();
    for (int k = 0; k < 4; k++) send(2'(k), 4'(k + 1));
    rdy_in = 4'b1111;
    cycle();
    rdy_in = 4'b0000;
    #1;
    n_cmp++;
    if (vout !== 4'b0000) begin
      n_err++;
      $display("FAIL concurrency_drain: got valid=%b need 0000", vout);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    send(2'd1, 4'h6);
    send(2'd3, 4'hC);
    vin = 1'b1; sel = 2'd1; din = 4'hF; rdy_in = 4'b1111;
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (vout !== 4'b0000 || z !== '0) begin
      n_err++;
      $display("FAIL midop_reset_async: got valid=%b z=%h need 0000/0", vout, z);
    end
    clear_model();
    @(posedge clk);
    #1;
    n_cmp++;
    if (vout !== 4'b0000 || z !== '0) begin
      n_err++;
      $display("FAIL midop_reset_edge: got valid=%b z=%h need 0000/0", vout, z);
    end
    @(negedge clk);
    rst = 1'b0; vin = 1'b0; rdy_in = 4'b0000;
    cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      vin    = 1'($urandom_range(0, 1));
      sel    = 2'($urandom_range(0, 3));
      din    = 4'($urandom_range(0, 15));
      rdy_in = 4'($urandom_range(0, 15));
      cycle();
    end
    vin = 1'b0; rdy_in = 4'b1111;
    cycle();
    cycle();
    rdy_in = 4'b0000;
  endtask

`ifdef CC_DEMUX14_COUNT_EN
  task automatic test_count_wrap();
    rst = 1'b1;
    #1;
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    vin = 1'b1; sel = 2'd3; rdy_in = 4'b1000;
    for (int i = 1; i <= 257; i++) begin
      din = 4'($urandom_range(0, 15));
      cycle();
      #1;
      if (i == 256) begin
        n_cmp++;
        if (cnt !== 32'hFF00_0000) begin
          n_err++;
          $display("FAIL count_255: got %h need ff000000", cnt);
        end
      end else if (i == 257) begin
        n_cmp++;
        if (cnt !== 32'h0000_0000) begin
          n_err++;
          $display("FAIL count_wrap: got %h need 00000000", cnt);
        end
      end
    end
    vin = 1'b0;
    cycle();
    rdy_in = 4'b0000;
  endtask
`endif

  initial begin
    rst = 1'b1; vin = 1'b0; sel = 2'd0; din = '0; rdy_in = 4'b0000;
    clear_model();
    @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_basic();
    test_backpressure();
    test_refill();
    test_concurrency();
    test_reset_midop();
    test_random();
`ifdef CC_DEMUX14_COUNT_EN
    test_count_wrap();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
